// File: rtl/note_scroller.sv
// note_scroller: pool of NUM_NOTES note sprites for the VGA renderer.
// Inserts load a note at SPAWN_X; every vs falling edge starts a sweep that
// moves each active note left by SCROLL_STEP (retiring notes that would pass
// x=0), one slot per cycle. For the current DrawX/DrawY it reports, one cycle
// later, whether the pixel lies inside an active note and its gray level.
// Optional build macro: NOTE_HIT_HIGHLIGHT_EN (notes in the hit zone at HIT_X
// draw at full white).
module note_scroller #(
  parameter int unsigned NUM_NOTES   = 8,
  parameter int unsigned SPAWN_X     = 620,
  parameter int unsigned SCROLL_STEP = 2,
  parameter int unsigned NOTE_W      = 12,
  parameter int unsigned NOTE_H      = 8,
  parameter int unsigned Y_BASE      = 300,
  parameter int unsigned PITCH_STEP  = 5,
  parameter int unsigned HIT_X       = 80
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         note_valid,
  input  logic [3:0]                   note_pitch,
  output logic                         note_ready,
  input  logic                         vs,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  output logic                         note_pixel,
  output logic [3:0]                   note_color,
  output logic [$clog2(NUM_NOTES):0]   note_count
);

  localparam int unsigned IdxW = $clog2(NUM_NOTES);
  localparam int unsigned CntW = IdxW + 1;

  localparam logic [9:0]  SpawnX     = 10'(SPAWN_X);
  localparam logic [9:0]  ScrollStep = 10'(SCROLL_STEP);
  localparam logic [10:0] NoteW11    = 11'(NOTE_W);
  localparam logic [9:0]  HalfH      = 10'(NOTE_H / 2);
  localparam logic [9:0]  YBase      = 10'(Y_BASE);
  localparam logic [9:0]  PitchStep  = 10'(PITCH_STEP);
  localparam logic [9:0]  HitX       = 10'(HIT_X);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NOTES - 1);

  typedef enum logic [0:0] {StIdle, StScroll} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   vs_q;
  logic [NUM_NOTES-1:0]   act_q, act_d;
  logic [3:0]             pitch_q [NUM_NOTES];
  logic [3:0]             pitch_d [NUM_NOTES];
  logic [9:0]             x_q [NUM_NOTES];
  logic [9:0]             x_d [NUM_NOTES];
  logic [CntW-1:0]        count_q, count_d;
  logic                   pixel_q;
  logic [3:0]             color_q;

  logic                   vs_fall;
  logic                   free_any;
  logic [IdxW-1:0]        free_idx;
  logic                   insert;

  assign vs_fall = vs_q & ~vs;

  // Lowest-index inactive slot receives the next insert.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  // A frame edge takes priority over an insert; the requester keeps valid high.
  assign note_ready = (state_q == StIdle) & ~vs_fall & free_any;
  assign insert     = note_valid & note_ready;

  // Next state: insert while idle, or sweep one slot per cycle while scrolling.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    pitch_d = pitch_q;
    x_d     = x_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (vs_fall) begin
          state_d = StScroll;
          idx_d   = '0;
        end else if (insert) begin
          act_d[free_idx]   = 1'b1;
          pitch_d[free_idx] = note_pitch;
          x_d[free_idx]     = SpawnX;
          count_d           = count_q + CntW'(1);
        end
      end
      StScroll: begin
        if (act_q[idx_q]) begin
          if (x_q[idx_q] < ScrollStep) begin
            act_d[idx_q] = 1'b0;
            count_d      = count_q - CntW'(1);
          end else begin
            x_d[idx_q] = x_q[idx_q] - ScrollStep;
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control, slot and frame-edge history registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      vs_q    <= 1'b1;
      act_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
        pitch_q[i] <= '0;
        x_q[i]     <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vs_q    <= vs;
      act_q   <= act_d;
      count_q <= count_d;
      pitch_q <= pitch_d;
      x_q     <= x_d;
    end
  end

  // Per-slot box test; right and bottom edges use 11 bits so they never wrap.
  logic [NUM_NOTES-1:0] slot_hit;
  logic [9:0]           slot_yc [NUM_NOTES];

  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_hit
    assign slot_yc[g]  = YBase - 10'(pitch_q[g]) * PitchStep;
    assign slot_hit[g] = act_q[g]
        && (DrawX >= x_q[g])
        && ({1'b0, DrawX} < ({1'b0, x_q[g]} + NoteW11))
        && (DrawY >= (slot_yc[g] - HalfH))
        && ({1'b0, DrawY} < ({1'b0, slot_yc[g]} + {1'b0, HalfH}));
  end

  // x of the lowest-index hit slot decides the colour when notes overlap.
  logic [9:0] hit_x;
  always_comb begin
    hit_x = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit_x = x_q[i];
      end
    end
  end

  logic [3:0] hit_color;

`ifdef NOTE_HIT_HIGHLIGHT_EN
  logic in_zone;
  assign in_zone   = (hit_x >= HitX) && ({1'b0, hit_x} < ({1'b0, HitX} + NoteW11));
  assign hit_color = in_zone ? 4'hF : 4'h8;
`else
  logic unused_hit_x;
  assign hit_color    = 4'h8;
  assign unused_hit_x = ^{hit_x, HitX};
`endif

  // Registered pixel output: one cycle behind DrawX/DrawY.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pixel_q <= 1'b0;
      color_q <= 4'h0;
    end else begin
      pixel_q <= |slot_hit;
      color_q <= (|slot_hit) ? hit_color : 4'h0;
    end
  end

  assign note_pixel = pixel_q;
  assign note_color = color_q;
  assign note_count = count_q;

endmodule

// File: tb/tb_note_scroller.sv
// Scoreboard bench for note_scroller: a frame-level note model predicts
// ready, count and pixel/colour; a monitor pops and compares each cycle.
module tb_note_scroller;

  localparam int N     = 8;
  localparam int SPAWN = 620;
  localparam int STEP  = 2;
  localparam int W     = 12;
  localparam int H     = 8;
  localparam int YB    = 300;
  localparam int PS    = 5;
  localparam int HX    = 80;
  localparam int CW    = $clog2(N) + 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          note_valid;
  logic [3:0]    note_pitch;
  logic          note_ready;
  logic          vs;
  logic [9:0]    DrawX;
  logic [9:0]    DrawY;
  logic          note_pixel;
  logic [3:0]    note_color;
  logic [CW-1:0] note_count;

  always #5 Clk = ~Clk;

  note_scroller #(
    .NUM_NOTES(N), .SPAWN_X(SPAWN), .SCROLL_STEP(STEP), .NOTE_W(W), .NOTE_H(H),
    .Y_BASE(YB), .PITCH_STEP(PS), .HIT_X(HX)
  ) dut (
    .Clk(Clk), .Reset(Reset), .note_valid(note_valid), .note_pitch(note_pitch),
    .note_ready(note_ready), .vs(vs), .DrawX(DrawX), .DrawY(DrawY),
    .note_pixel(note_pixel), .note_color(note_color), .note_count(note_count)
  );

  typedef struct {
    int    due;
    bit    ck_rdy;
    bit    rdy;
    bit    ck_cnt;
    int    cnt;
    bit    ck_pix;
    bit    pix;
    int    col;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Reference model: set of notes, whole-frame scroll after the sweep time.
  bit       m_act[N];
  int       m_pitch[N];
  int       m_x[N];
  int       m_cnt;
  int       m_busy;
  bit       m_vsp;
  bit       pend;
  logic [3:0] pp;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_pitch[i] = 0; m_x[i] = 0;
    end
    m_cnt = 0; m_busy = 0; m_vsp = 1;
  endfunction

  function automatic void m_scroll();
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (m_x[i] < STEP) begin
          m_act[i] = 0; m_cnt--;
        end else begin
          m_x[i] -= STEP;
        end
      end
    end
  endfunction

  function automatic void m_insert(input int p);
    for (int i = 0; i < N; i++) begin
      if (!m_act[i]) begin
        m_act[i] = 1; m_pitch[i] = p; m_x[i] = SPAWN; m_cnt++;
        return;
      end
    end
  endfunction

  function automatic void ref_pixel(input int dx, input int dy, output bit pix, output int col);
    pix = 0; col = 0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        int yc;
        yc = YB - m_pitch[i] * PS;
        if (dx >= m_x[i] && dx < m_x[i] + W && dy >= yc - H / 2 && dy < yc + H / 2) begin
          if (!pix) begin
            col = 8;
`ifdef NOTE_HIT_HIGHLIGHT_EN
            if (m_x[i] >= HX && m_x[i] < HX + W) col = 15;
`endif
          end
          pix = 1;
        end
      end
    end
  endfunction

  function automatic void push(input int due, input bit cr, input bit r, input bit cc,
                               input int c, input bit cp, input bit p, input int col,
                               input string nm);
    exp_t e;
    e.due = due; e.ck_rdy = cr; e.rdy = r; e.ck_cnt = cc; e.cnt = c;
    e.ck_pix = cp; e.pix = p; e.col = col; e.name = nm;
    q.push_back(e);
  endfunction

  // Query near a random active note half the time, else anywhere.
  task automatic rand_query(output int dx, output int dy);
    int k;
    k = $urandom_range(0, N - 1);
    if (m_act[k] && $urandom_range(0, 1) == 1) begin
      dx = m_x[k] + $urandom_range(0, W + 3) - 2;
      dy = YB - m_pitch[k] * PS + $urandom_range(0, H + 3) - (H / 2 + 2);
      if (dx < 0) dx = 0;
    end else begin
      dx = $urandom_range(0, 639);
      dy = $urandom_range(200, 320);
    end
  endtask

  // One clock: drive inputs, queue expectations, advance the model at the edge.
  task automatic tick(input logic vsv, input bit chk, input int dx, input int dy,
                      input string nm);
    bit vf, rdy, px;
    int col;
    @(negedge Clk);
    note_valid = pend; note_pitch = pp; vs = vsv;
    DrawX = 10'(dx); DrawY = 10'(dy);
    vf  = m_vsp & ~vsv;
    rdy = (m_busy == 0) && !vf && (m_cnt < N);
    push(cyc, 1, rdy, m_busy == 0, m_cnt, 0, 0, 0, nm);
    if (chk && m_busy == 0) begin
      ref_pixel(dx, dy, px, col);
      push(cyc + 1, 0, 0, 0, 0, 1, px, col, nm);
    end
    @(posedge Clk);
    m_vsp = vsv;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_scroll();
    end else if (vf) begin
      m_busy = N;
    end else if (pend && rdy) begin
      m_insert(int'(pp));
      pend = 0;
    end
  endtask

  task automatic frame();
    int dx, dy;
    rand_query(dx, dy);
    tick(1'b0, 1, dx, dy, "frame");
    repeat (N + 1) begin
      rand_query(dx, dy);
      tick(1'b1, 1, dx, dy, "frame");
    end
  endtask

  task automatic ins(input logic [3:0] p);
    pend = 1; pp = p;
    for (int k = 0; k < 50 && pend; k++) tick(1'b1, 0, 0, 0, "insert");
    vectors++;
    if (pend) begin
      miscompares++;
      $display("FAIL insert_timeout: request still pending, required accepted");
      pend = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #4;
    Reset = 0; pend = 0; note_valid = 0; vs = 1;
    m_reset();
    push(cyc + 1, 0, 0, 1, 0, 1, 0, 0, "reset");
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1;
    push(cyc, 1, 1, 1, 0, 1, 0, 0, "reset_release");
  endtask

  // Monitor: compare every due expectation late in the low clock phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #3;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          vectors++; miscompares++;
          $display("FAIL %s: stale expectation due %0d at cycle %0d", e.name, e.due, cyc);
        end else begin
          if (e.ck_rdy) begin
            vectors++;
            if (note_ready !== e.rdy) begin
              miscompares++;
              $display("FAIL %s ready @%0d: got %b want %0b", e.name, cyc, note_ready, e.rdy);
            end
          end
          if (e.ck_cnt) begin
            vectors++;
            if (note_count !== CW'(e.cnt)) begin
              miscompares++;
              $display("FAIL %s count @%0d: got %0d want %0d", e.name, cyc, note_count, e.cnt);
            end
          end
          if (e.ck_pix) begin
            vectors++;
            if (note_pixel !== e.pix || note_color !== 4'(e.col)) begin
              miscompares++;
              $display("FAIL %s pixel @%0d: got pix=%b col=%h want pix=%0b col=%h",
                       e.name, cyc, note_pixel, note_color, e.pix, 4'(e.col));
            end
          end
        end
      end
    end
  end

  initial begin
    int dx, dy, vs_lo;
    logic vsv;
    Reset = 0; vs = 1; note_valid = 0; note_pitch = 0; DrawX = 0; DrawY = 0;
    pend = 0; pp = 0;
    m_reset();
    do_reset();

    // Single note, pitch 2 -> yc = 290.
    ins(4'd2);
    tick(1'b1, 1, 625, 290, "single_hit");
    tick(1'b1, 1, 632, 290, "single_right_edge");
    tick(1'b1, 1, 625, 294, "single_bottom_edge");
    tick(1'b1, 1, 625, 286, "single_top_edge");

    // One frame: x -> 618.
    frame();
    tick(1'b1, 1, 618, 290, "scroll_hit");
    tick(1'b1, 1, 630, 290, "scroll_miss");
    tick(1'b1, 1, 617, 290, "scroll_left_edge");

    // Fill the pool, then hold a ninth request across frames until a retire.
    for (int i = 0; i < N - 1; i++) ins(4'($urandom_range(0, 15)));
    tick(1'b1, 1, 620, 250, "full");
    pend = 1; pp = 4'd7;
    for (int f = 0; f < 400 && pend; f++) frame();
    vectors++;
    if (pend) begin
      miscompares++;
      $display("FAIL held_insert: request still pending after 400 frames, required accepted");
      pend = 0;
    end
    tick(1'b1, 1, 0, 0, "after_held");

    // Reset in the middle of a sweep.
    tick(1'b0, 0, 0, 0, "pre_reset");
    tick(1'b1, 0, 0, 0, "pre_reset");
    tick(1'b1, 0, 0, 0, "pre_reset");
    do_reset();

    // Note walked into the hit zone: x = 620 - 268*2 = 84.
    ins(4'd0);
    for (int f = 0; f < 268; f++) frame();
    tick(1'b1, 1, 86, 300, "hit_zone");
    tick(1'b1, 1, 96, 300, "hit_zone_miss");

    // Randomized traffic: inserts, frame edges of varying width, queries.
    vs_lo = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1; pp = 4'($urandom_range(0, 15));
      end
      if (vs_lo > 0) begin
        vsv = 0; vs_lo--;
      end else if ($urandom_range(0, 15) == 0) begin
        vsv = 0; vs_lo = $urandom_range(0, 2);
      end else begin
        vsv = 1;
      end
      rand_query(dx, dy);
      tick(vsv, 1, dx, dy, "rand");
    end

    pend = 0;
    repeat (N + 3) tick(1'b1, 0, 0, 0, "drain");
    @(negedge Clk);
    #4;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
